select_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 2:1 `select` datapath mux. Grants exclusive ownership of the shared path to requester A or B and drives the mux `sel` line to match. Uses round-robin priority, a done/abandon handshake and an optional hold-time limit. Sits between the two producers and the `select` instance; its `sel` output connects directly to the mux select.

---
 rtl/select_arb_pkg.sv | 24 ++
 rtl/select_arbiter.sv | 159 +++++++++++++++
 tb/tb_select_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/select_arb_pkg.sv
// Shared definitions for select_arbiter: FSM state encoding, mux select
// values, last-owner encoding and the hold-counter width helper.
package select_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // Mux select values: 0 routes requester A, 1 routes requester B.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Encoding of the last_owner register.
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Hold-counter width; a disabled limit (0) still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned max_hold);
        return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage : select_arb_pkg

// File: rtl/select_arbiter.sv
// select_arbiter: two-requester round-robin arbiter that owns the sel line of
// the shared 2:1 select mux.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req_a    requester A wants the path (held until done or abandon)
//   req_b    requester B wants the path
//   done_a   A's final transfer cycle, honoured only while gnt_a=1
//   done_b   B's final transfer cycle, honoured only while gnt_b=1
//   gnt_a    A owns the path
//   gnt_b    B owns the path
//   sel      mux select (0 = A, 1 = B); holds its value while idle
//   busy     a grant is active
//   timeout  one-cycle pulse after a hold-limit forced release
//
// Every output is a flop loaded from the next-state decode, so there is no
// combinational path from any input to any output.
module select_arbiter
    import select_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy,
    output logic timeout
);

    localparam int unsigned CNT_W = cnt_width(MAX_HOLD);

    // Counter value seen during the last permitted grant cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT = '1;

    state_t           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
    logic             sel_q, sel_d;
    logic             gnt_a_q, gnt_b_q, busy_q;

    logic             hold_hit_c;
    logic             release_c;
    logic             grant_entry_c;

    // State, owner history, hold counter and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_B;
            hold_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            sel_q        <= SEL_A;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
            sel_q        <= sel_d;
            gnt_a_q      <= (state_d == OWN_A);
            gnt_b_q      <= (state_d == OWN_B);
            busy_q       <= (state_d != IDLE);
        end
    end

    // Next-state, owner tracking, hold counting and timeout decode.
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
        sel_d         = sel_q;
        release_c     = 1'b0;
        grant_entry_c = 1'b0;

        hold_hit_c = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the path last wins.
                if (req_a && (!req_b || (last_owner_q == OWNER_B))) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end

            OWN_A: begin
                release_c = done_a || !req_a || hold_hit_c;
                if (release_c) begin
                    // done takes precedence over the limit for timeout.
                    timeout_d = hold_hit_c && !done_a;
                    if (req_b) begin
                        state_d = OWN_B;
                    end else if (req_a) begin
                        state_d = OWN_A;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            OWN_B: begin
                release_c = done_b || !req_b || hold_hit_c;
                if (release_c) begin
                    timeout_d = hold_hit_c && !done_b;
                    if (req_a) begin
                        state_d = OWN_A;
                    end else if (req_b) begin
                        state_d = OWN_B;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A grant entry is any move into OWN_x from IDLE or via a release,
        // which includes re-granting the same requester.
        grant_entry_c = (state_d != IDLE) && ((state_q == IDLE) || release_c);

        if (grant_entry_c) begin
            hold_cnt_d   = '0;
            last_owner_d = (state_d == OWN_B) ? OWNER_B : OWNER_A;
        end else if ((state_q != IDLE) && (hold_cnt_q != HOLD_SAT)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end

        // sel follows the owner and is left untouched while idle.
        if (state_d == OWN_A) begin
            sel_d = SEL_A;
        end else if (state_d == OWN_B) begin
            sel_d = SEL_B;
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule : select_arbiter

// File: tb/tb_select_arbiter.sv
// Self-checking bench for select_arbiter: a MAX_HOLD=4 instance driven from a
// vector table plus hand sequences, and a MAX_HOLD=0 instance for the
// unlimited-hold case.
module tb_select_arbiter;

    logic clk;
    logic rst_n;

    logic req_a, req_b, done_a, done_b;
    logic gnt_a, gnt_b, sel, busy, timeout;

    logic req_a0, req_b0, done_a0, done_b0;
    logic gnt_a0, gnt_b0, sel0, busy0, timeout0;

    int n_cmp;
    int n_err;

    // Inputs {ra, rb, da, db} then expected {ga, gb, sel, busy, timeout}.
    typedef struct packed {
        logic [3:0] in;
        logic [4:0] ex;
    } vec_t;

    vec_t vecs[64];
    int   nv;

    select_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .done_a  (done_a),
        .done_b  (done_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    select_arbiter #(.MAX_HOLD(0)) dut_nolimit (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a0),
        .req_b   (req_b0),
        .done_a  (done_a0),
        .done_b  (done_b0),
        .gnt_a   (gnt_a0),
        .gnt_b   (gnt_b0),
        .sel     (sel0),
        .busy    (busy0),
        .timeout (timeout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] ex);
        check({tag, ".gnt_a"},   gnt_a,   ex[4]);
        check({tag, ".gnt_b"},   gnt_b,   ex[3]);
        check({tag, ".sel"},     sel,     ex[2]);
        check({tag, ".busy"},    busy,    ex[1]);
        check({tag, ".timeout"}, timeout, ex[0]);
    endtask

    task automatic add(input logic [3:0] in, input logic [4:0] ex);
        vecs[nv].in = in;
        vecs[nv].ex = ex;
        nv++;
    endtask

    task automatic drive(input logic [3:0] in);
        {req_a, req_b, done_a, done_b} = in;
    endtask

    // Advance one edge and land 1 time unit after it for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        nv    = 0;

        // Hand-computed table for MAX_HOLD=4, starting right after reset.
        add(4'b1000, 5'b10010); // A alone: granted
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b0010, 5'b00000); // done in 3rd grant cycle: idle
        add(4'b0000, 5'b00000);
        add(4'b1100, 5'b01110); // tie, last owner A: B wins
        add(4'b1001, 5'b10010); // B done, A waiting: handover
        add(4'b1110, 5'b01110); // A done, B waiting: handover
        add(4'b1101, 5'b10010); // B done: back to A
        add(4'b1100, 5'b10010);
        add(4'b1100, 5'b10010);
        add(4'b1100, 5'b10010);
        add(4'b1100, 5'b01111); // 4th edge: forced release to B
        add(4'b0100, 5'b01110); // timeout lasts one cycle
        add(4'b0000, 5'b00100); // B abandons: idle, sel stays 1
        add(4'b0001, 5'b00100); // stray done_b in idle ignored
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10011); // forced release, A re-granted
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10011); // timeout again after 4 cycles
        add(4'b0000, 5'b00000); // abandon
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b1000, 5'b10010);
        add(4'b0010, 5'b00000); // done coincides with limit: no timeout

        rst_n = 1'b0;
        drive(4'b0000);
        {req_a0, req_b0, done_a0, done_b0} = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 5'b00000);
        check("reset.nolimit_busy", busy0, 1'b0);
        #3;
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].in);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ex);
        end

        // Async reset mid-grant, then a tie after reset goes to A.
        drive(4'b1000);
        tick();
        check("pre_rst.gnt_a", gnt_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 5'b00000);
        drive(4'b1100);
        tick();
        check_all("rst_held", 5'b00000);
        #3;
        rst_n = 1'b1;
        tick();
        check_all("post_rst_tie", 5'b10010);
        drive(4'b1110);
        tick();
        check_all("alt_to_b", 5'b01110);
        drive(4'b1101);
        tick();
        check_all("alt_to_a", 5'b10010);
        drive(4'b1110);
        tick();
        check_all("alt_to_b2", 5'b01110);
        drive(4'b0000);
        tick();
        check_all("alt_idle", 5'b00100);

        // Unlimited hold: A keeps the path while B waits.
        req_a0 = 1'b1;
        tick();
        check("nolimit.first_gnt", gnt_a0, 1'b1);
        req_b0 = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            check("nolimit.gnt_a", gnt_a0, 1'b1);
            check("nolimit.gnt_b", gnt_b0, 1'b0);
            check("nolimit.sel", sel0, 1'b0);
            check("nolimit.busy", busy0, 1'b1);
            check("nolimit.timeout", timeout0, 1'b0);
        end
        req_a0 = 1'b0;
        tick();
        check("nolimit.handover", gnt_b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_select_arbiter
